sprite_reg_shadow: RTL

SPRITE_REG_SHADOW -- requirements
Module: sprite_reg_shadow

---
 rtl/sprite_reg_shadow.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sprite_reg_shadow.sv
// Shadow FIFO for display register writes: bus writes are queued and replayed
// to the display register port only during vertical blanking. Define FRAME_COUNT_EN
// to add a 16-bit frame counter readable at 9'h1FE.
module sprite_reg_shadow #(
  parameter int DEPTH = 16,
  parameter int AW    = 9,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          chipselect,
  input  logic          write,
  input  logic          read,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] writedata,
  output logic [DW-1:0] readdata,
  output logic          waitrequest,
  input  logic          vblank,
  output logic          out_write,
  output logic [AW-1:0] out_address,
  output logic [DW-1:0] out_writedata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);
  localparam logic [AW-1:0] STATUS_ADDR = {AW{1'b1}};
  localparam logic [AW-1:0] FRAME_ADDR  = {{(AW-1){1'b1}}, 1'b0};

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [AW+DW-1:0] fifo_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [0:0]    state_q, state_d;
  logic          vblank_q;
  logic          out_write_q, out_write_d;
  logic [AW-1:0] out_address_q, out_address_d;
  logic [DW-1:0] out_writedata_q, out_writedata_d;
  logic [DW-1:0] readdata_q, readdata_d;

  logic full, empty, push, pop, vblank_rise;

  assign full        = (count_q == FULL_CNT);
  assign empty       = (count_q == '0);
  assign waitrequest = chipselect & write & full;
  // Writes to the two status addresses never enter the queue.
  assign push        = chipselect & write & ~waitrequest & (address < FRAME_ADDR);
  assign pop         = (state_q == DRAIN) & ~empty & vblank;
  assign vblank_rise = vblank & ~vblank_q;

`ifdef FRAME_COUNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb frame_cnt_d = frame_cnt_q + 16'(vblank_rise);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) frame_cnt_q <= '0;
    else          frame_cnt_q <= frame_cnt_d;
  end
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    wr_ptr_d        = wr_ptr_q + PW'(push);
    rd_ptr_d        = rd_ptr_q + PW'(pop);
    count_d         = count_q;
    state_d         = state_q;
    out_write_d     = pop;
    out_address_d   = out_address_q;
    out_writedata_d = out_writedata_q;
    readdata_d      = '0;

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE:    if (vblank_rise && !empty) state_d = DRAIN;
      DRAIN:   if (!vblank || count_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (pop) begin
      {out_address_d, out_writedata_d} = fifo_mem[rd_ptr_q];
    end

    if (chipselect && read) begin
      if (address == STATUS_ADDR) begin
        readdata_d[7:0] = 8'(count_q);
        readdata_d[8]   = full;
        readdata_d[9]   = empty;
        readdata_d[10]  = (state_q == DRAIN);
      end
`ifdef FRAME_COUNT_EN
      else if (address == FRAME_ADDR) begin
        readdata_d[15:0] = frame_cnt_q;
      end
`endif
    end
  end

  // NOTE: the queue storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {address, writedata};
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      state_q         <= IDLE;
      vblank_q        <= 1'b0;
      out_write_q     <= 1'b0;
      out_address_q   <= '0;
      out_writedata_q <= '0;
      readdata_q      <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      state_q         <= state_d;
      vblank_q        <= vblank;
      out_write_q     <= out_write_d;
      out_address_q   <= out_address_d;
      out_writedata_q <= out_writedata_d;
      readdata_q      <= readdata_d;
    end
  end

  assign out_write     = out_write_q;
  assign out_address   = out_address_q;
  assign out_writedata = out_writedata_q;
  assign readdata      = readdata_q;

endmodule
